display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/display_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and types for the four-digit signed
//                seven-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Special digit codes understood by the seven-segment decoder
    localparam logic [3:0] DIG_BLANK = 4'd14;
    localparam logic [3:0] DIG_MINUS = 4'd15;

    // BCD nibble width and number of BCD digits produced by the converter
    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 3;

    // Conversion control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. Consumes one binary bit
//                per clock, MSB first, into three BCD nibbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic [BCD_DIGITS*BCD_W-1:0]   bcd
);

    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int BCD_TOT = BCD_DIGITS * BCD_W;

    logic [BIN_W-1:0]   r_bin;
    logic [BCD_TOT-1:0] r_bcd;
    logic [BCD_TOT-1:0] w_adj;
    logic [CNT_W-1:0]   r_cnt;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        assign w_adj[g*BCD_W +: BCD_W] =
            (r_bcd[g*BCD_W +: BCD_W] >= BCD_W'(5)) ?
            (r_bcd[g*BCD_W +: BCD_W] + BCD_W'(3)) :
             r_bcd[g*BCD_W +: BCD_W];
    end

    // Load on start, then shift one bit per cycle until BIN_W bits are consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[BCD_TOT-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= CNT_W'(BIN_W);
        end
    end

    assign busy = (r_cnt != '0);
    assign bcd  = r_bcd;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Captures a signed value, converts it to decimal digits and
//                time-multiplexes four digit slots to a seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int VAL_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [VAL_W-1:0] value,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              en,
    output logic [3:0]              num
);

    localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCD_TOT = BCD_DIGITS * BCD_W;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_sign;
    logic [3:0]         r_slot [4];
    logic [CNT_W-1:0]   r_refresh;
    logic [1:0]         r_en;

    logic [VAL_W-1:0]   w_val_u;
    logic [VAL_W-1:0]   w_mag;
    logic               w_start;
    logic               w_bb_busy;
    logic [BCD_TOT-1:0] w_bcd;
    logic [BCD_W-1:0]   w_hund;
    logic [BCD_W-1:0]   w_tens;
    logic [BCD_W-1:0]   w_ones;
    logic               w_wrap;

    // Magnitude as unsigned VAL_W bits; the most negative value maps cleanly
    // onto its own bit pattern (e.g. -512 -> 512).
    assign w_val_u = value;
    assign w_mag   = w_val_u[VAL_W-1] ? (~w_val_u + VAL_W'(1)) : w_val_u;
    assign w_start = (r_state == ST_IDLE) && load;

    bin2bcd_seq #(
        .BIN_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_mag),
        .busy  (w_bb_busy),
        .bcd   (w_bcd)
    );

    assign w_hund = w_bcd[2*BCD_W +: BCD_W];
    assign w_tens = w_bcd[1*BCD_W +: BCD_W];
    assign w_ones = w_bcd[0*BCD_W +: BCD_W];

    // Conversion control; display slots change only on the CONV->DONE edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sign    <= 1'b0;
            r_slot[3] <= DIG_BLANK;
            r_slot[2] <= DIG_BLANK;
            r_slot[1] <= DIG_BLANK;
            r_slot[0] <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                        r_sign  <= w_val_u[VAL_W-1];
                    end
                end
                ST_CONV: begin
                    if (!w_bb_busy) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_slot[3] <= r_sign ? DIG_MINUS : DIG_BLANK;
                        r_slot[2] <= (w_hund == '0) ? DIG_BLANK : w_hund;
                        r_slot[1] <= ((w_hund == '0) && (w_tens == '0)) ? DIG_BLANK : w_tens;
                        r_slot[0] <= w_ones;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

    // Free-running refresh divider stepping the active digit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_en      <= 2'd0;
        end else if (w_wrap) begin
            r_refresh <= '0;
            r_en      <= r_en + 2'd1;
        end else begin
            r_refresh <= r_refresh + CNT_W'(1);
        end
    end

    // Slot mux: purely combinational so a new slot and new digits align
    always_comb begin
        num = r_slot[r_en];
    end

    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule : display_scan_ctrl
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_ctrl
//  Description : Self-checking bench for display_scan_ctrl with a decimal
//                arithmetic reference model and cycle-count refresh model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int VW   = 10;
    localparam int RDIV = 4;
    localparam logic [15:0] RESET_DISP = {4'd14, 4'd14, 4'd14, 4'd0};

    logic                 clk;
    logic                 rst;
    logic                 load;
    logic signed [VW-1:0] value;
    logic                 busy;
    logic                 done;
    logic [1:0]           en;
    logic [3:0]           num;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edges = 0;
    logic [15:0] cur_disp;

    display_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .VAL_W       (VW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .en    (en),
        .num   (num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges elapsed since the last reset edge
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Decimal display expected for a signed value, packed {slot3..slot0}
    function automatic logic [15:0] model_disp(input int v);
        int m, h, t, o;
        logic [3:0] s3, s2, s1, s0;
        m  = (v < 0) ? -v : v;
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        s3 = (v < 0) ? 4'd15 : 4'd14;
        s2 = (h == 0) ? 4'd14 : 4'(h);
        s1 = (h == 0 && t == 0) ? 4'd14 : 4'(t);
        s0 = 4'(o);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [1:0] model_en(input int e);
        return 2'((e / RDIV) % 4);
    endfunction

    function automatic logic [3:0] slot_of(input logic [15:0] d, input logic [1:0] s);
        logic [15:0] sh;
        sh = d >> (4 * int'(s));
        return sh[3:0];
    endfunction

    task automatic test_reset();
        logic [1:0] exp_en;
        rst = 1'b1; load = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++;
        if (en !== 2'd0) begin n_bad++; $display("FAIL reset_en got %0d want 0", en); end
        n_cmp++;
        if (num !== 4'd0) begin n_bad++; $display("FAIL reset_num got %0d want 0", num); end
        cur_disp = RESET_DISP;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_en = model_en(edges);
            n_cmp++;
            if (en !== exp_en) begin n_bad++; $display("FAIL idle_en cyc %0d got %0d want %0d", i, en, exp_en); end
            n_cmp++;
            if (num !== slot_of(cur_disp, exp_en)) begin
                n_bad++; $display("FAIL idle_num cyc %0d got %0d want %0d", i, num, slot_of(cur_disp, exp_en));
            end
        end
    endtask

    // One load of v (entered and left on a negedge). dup_at / rst_at name the
    // cycle after acceptance at which a second load or a reset is applied (0 = none).
    task automatic run_conv(input int v, input int dup_at, input int dup_v, input int rst_at);
        logic [15:0] new_disp, exp_disp;
        logic        exp_busy, exp_done, aborted;
        logic [1:0]  exp_en;
        int          dones;
        new_disp = model_disp(v);
        dones    = 0;
        aborted  = 1'b0;
        value = VW'(v); load = 1'b1;
        for (int i = 0; i <= VW + 4; i++) begin
            @(negedge clk);
            load = 1'b0; rst = 1'b0; value = VW'($urandom);
            aborted = (rst_at > 0) && (i >= rst_at);
            if (aborted) begin
                exp_busy = 1'b0; exp_done = 1'b0; exp_disp = RESET_DISP;
            end else begin
                exp_busy = (i <= VW + 1);
                exp_done = (i == VW + 1);
                exp_disp = (i >= VW + 1) ? new_disp : cur_disp;
            end
            if (done === 1'b1) dones++;
            exp_en = model_en(edges);
            n_cmp++;
            if (busy !== exp_busy) begin n_bad++; $display("FAIL busy v=%0d cyc %0d got %0b want %0b", v, i, busy, exp_busy); end
            n_cmp++;
            if (done !== exp_done) begin n_bad++; $display("FAIL done v=%0d cyc %0d got %0b want %0b", v, i, done, exp_done); end
            n_cmp++;
            if (en !== exp_en) begin n_bad++; $display("FAIL en v=%0d cyc %0d got %0d want %0d", v, i, en, exp_en); end
            n_cmp++;
            if (num !== slot_of(exp_disp, exp_en)) begin
                n_bad++; $display("FAIL num v=%0d cyc %0d got %0d want %0d", v, i, num, slot_of(exp_disp, exp_en));
            end
            if (i + 1 == dup_at) begin load = 1'b1; value = VW'(dup_v); end
            if (i + 1 == rst_at) rst = 1'b1;
        end
        cur_disp = aborted ? RESET_DISP : new_disp;
        n_cmp++;
        if (dones != ((rst_at > 0) ? 0 : 1)) begin
            n_bad++; $display("FAIL done_count v=%0d got %0d want %0d", v, dones, (rst_at > 0) ? 0 : 1);
        end
    endtask

    task automatic test_negative();
        run_conv(-123, 0, 0, 0);
    endtask

    task automatic test_boundaries();
        run_conv(7, 0, 0, 0);
        run_conv(-512, 0, 0, 0);
        run_conv(511, 0, 0, 0);
        run_conv(0, 0, 0, 0);
        run_conv(-1, 0, 0, 0);
        run_conv(100, 0, 0, 0);
    endtask

    task automatic test_load_ignored();
        run_conv(40, 3, 99, 0);
        run_conv(-5, VW + 1, 321, 0);
    endtask

    task automatic test_reset_abort();
        run_conv(-88, 0, 0, 5);
    endtask

    task automatic test_wrap_align();
        int guard;
        guard = 0;
        while ((edges % RDIV) != 0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if ((edges % RDIV) != 0) begin n_bad++; $display("FAIL wrap_align got phase %0d want 0", edges % RDIV); end
        run_conv(-305, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int v, gap;
        logic [1:0] exp_en;
        for (int k = 0; k < 10; k++) begin
            v   = int'($urandom_range(1023)) - 512;
            gap = int'($urandom_range(3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                exp_en = model_en(edges);
                n_cmp++;
                if (num !== slot_of(cur_disp, exp_en)) begin
                    n_bad++; $display("FAIL gap_num got %0d want %0d", num, slot_of(cur_disp, exp_en));
                end
            end
            run_conv(v, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; cur_disp = RESET_DISP;
        test_reset();
        test_negative();
        test_boundaries();
        test_load_ignored();
        test_reset_abort();
        test_wrap_align();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_display_scan_ctrl
`default_nettype wire
